booth_seq_mult: RTL

//   Parametrised iterative radix-2 Booth multiplier; one Booth step (add/sub + arithmetic shift) per clock.

---
 rtl/booth_seq_mult_if.sv | 29 ++
 rtl/booth_seq_mult.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult_if.sv
// rtl/booth_seq_mult_if.sv - handshake/operand/result bundle for booth_seq_mult
//
// Purpose: groups the request side (start, is_signed, a, b) and the response
//          side (ready, busy, done, product) of the sequential Booth multiplier.
// Modports:
//   master - requester: drives start/is_signed/a/b, observes ready/busy/done/product
//   slave  - multiplier: observes the request, drives ready/busy/done/product
interface booth_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - iterative radix-2 Booth multiplier, one Booth step per clock
//
// Purpose: shared multi-cycle multiplier, signed or unsigned per operation,
//          one operation in flight, result held until the next accepted start.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - booth_seq_mult_if.slave: start/is_signed/a/b in, ready/busy/done/product out
// Optional feature macro: BOOTH_EARLY_TERM_EN
//   When defined, a CALC cycle whose remaining multiplier bits all equal Q_1
//   skips straight to the end with one variable arithmetic shift.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_seq_mult_if.slave      bus
);
    // Two bits of headroom on Acc/M keep -2^(WIDTH-1) negation and
    // unsigned full-scale operands exact.
    localparam int AW = WIDTH + 2;
    localparam int QW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam int SW = AW + QW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_m;
    logic [AW-1:0]        r_acc;
    logic [QW-1:0]        r_q;
    logic                 r_q1;
    logic [CW-1:0]        r_count;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [AW-1:0]        w_m_ext;
    logic [QW-1:0]        w_q_ext;
    logic [AW-1:0]        w_sum;
    logic [SW-1:0]        w_step;
    logic [SW-1:0]        w_next;
    logic [CW-1:0]        w_next_count;

    assign w_m_ext = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    assign w_q_ext = bus.is_signed ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};

    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b10:   w_sum = r_acc - r_m;
            2'b01:   w_sum = r_acc + r_m;
            default: w_sum = r_acc;
        endcase
    end

    // Arithmetic right shift of {sum, Q, Q_1} by one: Q_1 falls off the end.
    assign w_step = {w_sum[AW-1], w_sum, r_q};

`ifdef BOOTH_EARLY_TERM_EN
    logic          w_et_hit;
    logic [SW-1:0] w_et_shift;

    // Remaining multiplier bits Q[count-1:0] all equal to Q_1 means every
    // remaining Booth pair is 00 or 11, so only shifting is left to do.
    always_comb begin
        w_et_hit = 1'b1;
        for (int i = 0; i < QW; i++) begin
            if ((i < int'(r_count)) && (r_q[i] != r_q1)) begin
                w_et_hit = 1'b0;
            end
        end
    end

    assign w_et_shift   = $signed({r_acc, r_q, r_q1}) >>> r_count;
    assign w_next       = w_et_hit ? w_et_shift : w_step;
    assign w_next_count = w_et_hit ? '0 : (r_count - 1'b1);
`else
    assign w_next       = w_step;
    assign w_next_count = r_count - 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_count   <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_m     <= w_m_ext;
                        r_q     <= w_q_ext;
                        r_q1    <= 1'b0;
                        r_acc   <= '0;
                        r_count <= CW'(WIDTH + 1);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_next[SW-1:QW+1];
                    r_q     <= w_next[QW:1];
                    r_q1    <= w_next[0];
                    r_count <= w_next_count;
                    if (w_next_count == '0) begin
                        r_product <= w_next[2*WIDTH:1];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule
